// File: rtl/scan_sig_compactor.sv
// Serial signature compactor: folds scan-chain output into a SISR, counts bits/patterns,
// and compares the final signature against a golden value.
module scan_sig_compactor #(
  parameter int                   CHAIN_LEN    = 7,
  parameter int                   NUM_PATTERNS = 16,
  parameter int                   SIG_WIDTH    = 16,
  parameter logic [SIG_WIDTH-1:0] POLY         = 16'h1021,
  parameter logic [SIG_WIDTH-1:0] SEED         = 16'h0000,
  parameter logic [SIG_WIDTH-1:0] GOLDEN       = 16'h0000
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 scan_data,
  input  logic                 test_control,
  input  logic                 start,
  output logic [SIG_WIDTH-1:0] signature,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 frame_err
);

  localparam int BIT_W = $clog2(CHAIN_LEN);
  localparam int PAT_W = (NUM_PATTERNS > 1) ? $clog2(NUM_PATTERNS) : 1;
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_LEN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_CMP  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state_reg;
  logic [BIT_W-1:0]     bit_cnt_reg;
  logic [PAT_W-1:0]     pat_cnt_reg;
  logic [SIG_WIDTH-1:0] sig_next;

  // Galois-style SISR step with the serial bit injected at the LSB
  always_comb begin
    sig_next = {signature[SIG_WIDTH-2:0], 1'b0}
             ^ (signature[SIG_WIDTH-1] ? POLY : '0)
             ^ {{(SIG_WIDTH-1){1'b0}}, scan_data};
  end

  assign busy = (state_reg == ST_RUN) || (state_reg == ST_CMP);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      signature   <= SEED;
      bit_cnt_reg <= '0;
      pat_cnt_reg <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          // The start cycle itself never compacts, whatever test_control says
          if (start) begin
            state_reg   <= ST_RUN;
            signature   <= SEED;
            bit_cnt_reg <= '0;
            pat_cnt_reg <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            frame_err   <= 1'b0;
          end
        end
        ST_RUN: begin
          if (test_control) begin
            signature <= sig_next;
            if (bit_cnt_reg == BIT_LAST) begin
              bit_cnt_reg <= '0;
              // Pattern counter stays at its last value once the session ends
              if (pat_cnt_reg == PAT_LAST) begin
                state_reg <= ST_CMP;
              end else begin
                pat_cnt_reg <= pat_cnt_reg + 1'b1;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 1'b1;
            end
          end else if (bit_cnt_reg != '0) begin
            frame_err <= 1'b1;
          end
        end
        ST_CMP: begin
          done      <= 1'b1;
          pass      <= (signature == GOLDEN) && !frame_err;
          state_reg <= ST_DONE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_sig_compactor.sv
// Directed self-checking bench for scan_sig_compactor using three parameterisations
// that share clock and stimulus; each check targets the instance relevant at that point.
module tb_scan_sig_compactor;

  logic clock;
  logic reset_n;
  logic scan_data;
  logic test_control;
  logic start;

  logic [15:0] a_sig, b_sig, c_sig;
  logic a_busy, a_done, a_pass, a_fe;
  logic b_busy, b_done, b_pass, b_fe;
  logic c_busy, c_done, c_pass, c_fe;

  int checks = 0;
  int errors = 0;

  scan_sig_compactor dut_a (
    .clock(clock), .reset_n(reset_n), .scan_data(scan_data),
    .test_control(test_control), .start(start), .signature(a_sig),
    .busy(a_busy), .done(a_done), .pass(a_pass), .frame_err(a_fe)
  );

  scan_sig_compactor #(.NUM_PATTERNS(1), .GOLDEN(16'h007F)) dut_b (
    .clock(clock), .reset_n(reset_n), .scan_data(scan_data),
    .test_control(test_control), .start(start), .signature(b_sig),
    .busy(b_busy), .done(b_done), .pass(b_pass), .frame_err(b_fe)
  );

  scan_sig_compactor #(.NUM_PATTERNS(1), .SEED(16'h8000)) dut_c (
    .clock(clock), .reset_n(reset_n), .scan_data(scan_data),
    .test_control(test_control), .start(start), .signature(c_sig),
    .busy(c_busy), .done(c_done), .pass(c_pass), .frame_err(c_fe)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  logic [15:0] ones_seq [7];

  initial begin
    ones_seq = '{16'h0001, 16'h0003, 16'h0007, 16'h000F, 16'h001F, 16'h003F, 16'h007F};
    reset_n = 1'b1; start = 1'b0; test_control = 1'b0; scan_data = 1'b0;
    #2 reset_n = 1'b0;
    #10;
    check_val("rst_sig_a", a_sig, 16'h0000);
    check_val("rst_busy", a_busy, 1'b0);
    check_val("rst_done", a_done, 1'b0);
    check_val("rst_pass", a_pass, 1'b0);
    check_val("rst_fe", a_fe, 1'b0);
    check_val("rst_sig_c_seed", c_sig, 16'h8000);
    reset_n = 1'b1;

    // All-ones pattern into the single-pattern instance; start cycle has test_control high
    start = 1'b1; test_control = 1'b1; scan_data = 1'b1;
    tick();
    start = 1'b0;
    check_val("b_start_no_compact", b_sig, 16'h0000);
    check_val("b_busy_rise", b_busy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check_val($sformatf("b_sig_bit%0d", i), b_sig, ones_seq[i]);
    end
    check_val("b_cmp_done_low", b_done, 1'b0);
    check_val("b_cmp_busy", b_busy, 1'b1);
    test_control = 1'b0; scan_data = 1'b0;
    tick();
    check_val("b_done", b_done, 1'b1);
    check_val("b_pass", b_pass, 1'b1);
    check_val("b_busy_fall", b_busy, 1'b0);
    check_val("b_sig_hold", b_sig, 16'h007F);
    tick();
    check_val("b_done_hold", b_done, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("b_restart_done", b_done, 1'b0);
    check_val("b_restart_sig", b_sig, 16'h0000);
    check_val("b_restart_busy", b_busy, 1'b1);

    // Instance a is mid-session here; reset must act without a clock edge
    check_val("a_busy_mid", a_busy, 1'b1);
    check_val("a_sig_mid", a_sig, 16'h007F);
    #2 reset_n = 1'b0;
    #1;
    check_val("async_sig", a_sig, 16'h0000);
    check_val("async_busy", a_busy, 1'b0);
    check_val("async_done", a_done, 1'b0);
    check_val("async_pass", a_pass, 1'b0);
    check_val("async_fe", a_fe, 1'b0);
    reset_n = 1'b1;
    tick();

    // Feedback path: seed MSB set, first accepted bit 0
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("c_seed_load", c_sig, 16'h8000);
    test_control = 1'b1; scan_data = 1'b0;
    tick();
    check_val("c_feedback", c_sig, 16'h1021);
    test_control = 1'b0;
    reset_n = 1'b0;
    #1 reset_n = 1'b1;
    tick();

    // Full default session, zero data, gaps only on pattern boundaries, stray start mid-run
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("a_busy_start", a_busy, 1'b1);
    for (int p = 0; p < 16; p++) begin
      for (int b = 0; b < 7; b++) begin
        test_control = 1'b1; scan_data = 1'b0;
        start = (p == 5 && b == 3);
        tick();
        start = 1'b0;
        if (p == 15 && b == 6) begin
          check_val("a_cmp_done_low", a_done, 1'b0);
          check_val("a_cmp_busy", a_busy, 1'b1);
        end
      end
      if (p < 15) begin
        test_control = 1'b0;
        tick();
      end
    end
    test_control = 1'b0;
    tick();
    check_val("a_done", a_done, 1'b1);
    check_val("a_pass", a_pass, 1'b1);
    check_val("a_fe_clean", a_fe, 1'b0);
    check_val("a_sig_zero", a_sig, 16'h0000);
    check_val("a_busy_fall", a_busy, 1'b0);

    // New session from DONE with a mid-pattern gap
    start = 1'b1;
    tick();
    start = 1'b0;
    check_val("fr_done_clear", a_done, 1'b0);
    check_val("fr_sig_seed", a_sig, 16'h0000);
    check_val("fr_busy", a_busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      test_control = 1'b1;
      tick();
    end
    check_val("fr_fe_before_gap", a_fe, 1'b0);
    test_control = 1'b0;
    tick();
    check_val("fr_fe_set", a_fe, 1'b1);
    for (int i = 0; i < 109; i++) begin
      test_control = 1'b1;
      tick();
    end
    check_val("fr_cmp_busy", a_busy, 1'b1);
    test_control = 1'b0;
    tick();
    check_val("fr_done", a_done, 1'b1);
    check_val("fr_pass_low", a_pass, 1'b0);
    check_val("fr_fe_sticky", a_fe, 1'b1);
    check_val("fr_sig", a_sig, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
